counter_updown_mod: RTL

//   Parametrised up/down counter with a programmable modulo limit, a synchronous

---
 rtl/counter_updown_mod.sv | 64 ++++++
 1 files changed

// File: rtl/counter_updown_mod.sv
// counter_updown_mod: up/down modulo counter with load, clear, terminal-count pulse and sticky overflow.
// Define COUNTER_SATURATE_EN to hold at the boundary instead of wrapping.
module counter_updown_mod #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned INIT  = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             en,
    input  logic             up,
    input  logic [WIDTH-1:0] limit,
    output logic [WIDTH-1:0] out,
    output logic             tc,
    output logic             ovf
);
    localparam logic [WIDTH-1:0] INIT_V = WIDTH'(INIT);
`ifdef COUNTER_SATURATE_EN
    localparam logic SAT = 1'b1;
`else
    localparam logic SAT = 1'b0;
`endif
    logic [WIDTH-1:0] out_q, out_d;
    logic             tc_q, tc_d, ovf_q, ovf_d;
    logic             at_top, at_bot;
    assign at_top = out_q >= limit;
    assign at_bot = out_q == '0;
    always_comb begin
        out_d = out_q;
        tc_d  = 1'b0;
        ovf_d = ovf_q;
        if (clr) begin
            out_d = INIT_V;
            ovf_d = 1'b0;
        end else if (load) begin
            out_d = (load_val > limit) ? limit : load_val;
        end else if (en && up) begin
            out_d = at_top ? (SAT ? limit : '0) : out_q + 1'b1;
            tc_d  = at_top;
            ovf_d = ovf_q | at_top;
        end else if (en) begin
            // Wrap check on zero comes before the out>limit pull-down, so limit=0 still pulses tc.
            out_d = at_bot ? (SAT ? '0 : limit) : (out_q > limit) ? limit : out_q - 1'b1;
            tc_d  = at_bot;
            ovf_d = ovf_q | at_bot;
        end
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_q <= INIT_V;
            tc_q  <= 1'b0;
            ovf_q <= 1'b0;
        end else begin
            out_q <= out_d;
            tc_q  <= tc_d;
            ovf_q <= ovf_d;
        end
    end
    assign out = out_q;
    assign tc  = tc_q;
    assign ovf = ovf_q;
endmodule
